ydriver_timing_gen: RTL and testbench
=====================================

Name: ydriver_timing_gen

Overview:
- Drives the Y (common/row) driver pins of the DMG LCD: start pulse S, line latch clock CPL, and AC polarity FR.
- Sits in the LCD controller and is the source end of the S/CPL/FR interface that the Y driver's control logic consumes.
- Runs a dot counter and a line counter from the single system clock.
- Also emits line and frame strobes and the current line number for the rest of the controller.

Parameters:
- CLKS_PER_LINE, 456, clocks per line; dot counter wraps at this value.
- LINES_PER_FRAME, 154, lines per frame (144 visible + 10 blank); line counter wraps at this value.
- CPL_START, 8, dot index at which CPL rises; must be ≥1 so S settles before CPL.
- CPL_WIDTH, 4, CPL high time in clocks; CPL_START+CPL_WIDTH ≤ CLKS_PER_LINE.
- FR_LINES, 13, lines between FR toggles; must be odd so FR has no DC component across frames.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- lcd_on  in  1  display enable; low forces the idle state
- S  out  1  frame start pulse to Y driver
- CPL  out  1  line latch/shift clock to Y driver
- FR  out  1  LCD drive polarity
- line_strobe  out  1  one-clock pulse at dot 0 of every line
- frame_strobe  out  1  one-clock pulse at dot 0 of line 0
- ly  out  8  current line number, 0..LINES_PER_FRAME-1
- active  out  1  high while lcd_on is accepted and counters are running

Behaviour:
- Reset and idle: rst=1, or lcd_on=0, forces the following at the next edge.
  - dot=0, line=0, fr_cnt=0.
  - S=0, CPL=0, FR=0, line_strobe=0, frame_strobe=0, ly=0, active=0.
  - rst has priority over lcd_on.
- Start: the first edge with lcd_on=1 (rst=0) after idle loads dot=0, line=0, active=1.
  - Every output is a flop whose value matches the counter values loaded on the same edge. There is no extra pipeline latency.
- Dot counter: increments each clock; at CLKS_PER_LINE-1 it wraps to 0 and the line counter increments.
- Line counter: wraps from LINES_PER_FRAME-1 to 0.
- ly equals the line counter.
- line_strobe=1 exactly when dot==0 and active.
- frame_strobe=1 exactly when dot==0, line==0 and active.
- S=1 for every dot of line 0 (CLKS_PER_LINE consecutive clocks); otherwise 0. CPL therefore samples S=1 exactly once per frame.
- CPL=1 when CPL_START ≤ dot < CPL_START+CPL_WIDTH and active; one pulse per line, 154 per frame.
- FR:
  - fr_cnt counts line boundaries (dot wrapping to 0).
  - When fr_cnt reaches FR_LINES-1 and a line boundary occurs, FR inverts on that same edge and fr_cnt returns to 0.
  - fr_cnt does not reset at frame wrap, so the toggle phase drifts frame to frame (154 mod 13 = 11).
- lcd_on falling mid-line or mid-frame: the next edge goes to idle per above, with no completion of the current line. A CPL pulse in progress is truncated.
- lcd_on re-asserting: restarts from dot 0, line 0 with FR=0.
- A one-clock lcd_on pulse produces exactly one active cycle: dot 0, line 0, S=1, both strobes high.
- Counter widths: dot uses clog2(CLKS_PER_LINE) bits, line uses 8 bits, fr_cnt uses clog2(FR_LINES) bits.
- Parameter violations: CPL_START=0, CPL_START+CPL_WIDTH > CLKS_PER_LINE, even FR_LINES, or LINES_PER_FRAME > 256 are elaboration errors, enforced by an assertion.

Decomposition:
- Package ydriver_pkg holds:
  - DMG_CLKS_PER_LINE=456, DMG_LINES_PER_FRAME=154, DMG_VISIBLE_LINES=144.
  - Default CPL_START/CPL_WIDTH/FR_LINES.
  - Width helper constants for dot and line.
- One sub-module, ydriver_wrap_counter: parameterised modulo-N counter with clear and enable inputs and a wrap output. It is instantiated three times (dot, line, fr_cnt). The wrap output of each chains into the enable of the next, with fr_cnt enabled by the dot wrap.

Test Plan:
- Reset then lcd_on=1, defaults -> first active cycle: dot 0, S=1, line_strobe=1, frame_strobe=1, ly=0, CPL=0. CPL is high on cycles 8..11 only. S falls at cycle 456, where line_strobe=1 and ly=1.
- Full frame, defaults -> exactly 154 CPL pulses and 1 S pulse. frame_strobe period is 70224 clocks. S and CPL are never both rising on the same edge.
- FR cadence -> FR is 0 for lines 0..12 and toggles to 1 at the line-13 boundary (cycle 5928), then at cycle 11856. Over 2 frames FR shows 23 transitions (308 line boundaries / 13 = 23, remainder 9).
- lcd_on dropped at line 50, dot 9 (mid-CPL) -> next edge: CPL=0, S=0, FR=0, ly=0, active=0. Re-enable restarts with frame_strobe=1 on the first active cycle.
- rst=1 asserted together with lcd_on=1 mid-frame -> all outputs 0 on the next edge. Release resumes from dot 0, line 0 exactly as after power-up.
- Small parameters (CLKS_PER_LINE=16, LINES_PER_FRAME=4, CPL_START=2, CPL_WIDTH=3, FR_LINES=3) -> S high for cycles 0..15, frame period 64. FR toggles at cycles 48, 96, 144. Line and frame wrap occur on the same edge without glitches.

Source files
------------

// File: rtl/ydriver_pkg.sv
// Shared constants, widths and state type for the DMG LCD Y-driver timing generator.
package ydriver_pkg;

  localparam int unsigned DMG_CLKS_PER_LINE   = 456;
  localparam int unsigned DMG_LINES_PER_FRAME = 154;
  localparam int unsigned DMG_VISIBLE_LINES   = 144;

  localparam int unsigned DEF_CPL_START = 8;
  localparam int unsigned DEF_CPL_WIDTH = 4;
  localparam int unsigned DEF_FR_LINES  = 13;

  localparam int unsigned DMG_DOT_W = $clog2(DMG_CLKS_PER_LINE);
  localparam int unsigned LINE_W    = 8;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ydrv_state_t;

endpackage

// File: rtl/ydriver_wrap_counter.sv
// Modulo-N counter with clear and enable; exposes its next value and a wrap flag.
module ydriver_wrap_counter #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count_next,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  assign wrap = !clr && en && (count == LAST);

  always_comb begin
    count_next = count;
    if (clr || wrap) count_next = '0;
    else if (en)     count_next = count + W'(1);
  end

  always_ff @(posedge clk) begin
    count <= count_next;
  end

endmodule

// File: rtl/ydriver_timing_gen.sv
// Generates S/CPL/FR for the DMG LCD Y driver plus line/frame strobes and ly.
module ydriver_timing_gen
  import ydriver_pkg::*;
#(
  parameter int unsigned CLKS_PER_LINE   = DMG_CLKS_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = DMG_LINES_PER_FRAME,
  parameter int unsigned CPL_START       = DEF_CPL_START,
  parameter int unsigned CPL_WIDTH       = DEF_CPL_WIDTH,
  parameter int unsigned FR_LINES        = DEF_FR_LINES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_on,
  output logic       S,
  output logic       CPL,
  output logic       FR,
  output logic       line_strobe,
  output logic       frame_strobe,
  output logic [7:0] ly,
  output logic       active
);
  localparam int unsigned DOT_W = cnt_width(CLKS_PER_LINE);
  localparam int unsigned FR_W  = cnt_width(FR_LINES);

  if (CPL_START == 0 || CPL_START + CPL_WIDTH > CLKS_PER_LINE ||
      FR_LINES % 2 == 0 || LINES_PER_FRAME > 256) begin : g_param_check
    $error("ydriver_timing_gen: illegal parameter combination");
  end

  ydrv_state_t       state_q, state_d;
  logic              clr, run, going;
  logic [DOT_W-1:0]  dot_next;
  logic [LINE_W-1:0] line_next;
  logic [FR_W-1:0]   fr_next;
  logic              dot_wrap, line_wrap, fr_wrap;
  logic              s_d, cpl_d, fr_d, ls_d, fs_d;
  logic [7:0]        ly_d;

  assign clr = rst || !lcd_on;
  // Counters hold at zero on the start edge, so the first active cycle is dot 0.
  assign run = (state_q == ST_RUN);

  ydriver_wrap_counter #(.N(CLKS_PER_LINE), .W(DOT_W)) u_dot (
    .clk(clk), .clr(clr), .en(run), .count_next(dot_next), .wrap(dot_wrap)
  );

  ydriver_wrap_counter #(.N(LINES_PER_FRAME), .W(LINE_W)) u_line (
    .clk(clk), .clr(clr), .en(dot_wrap), .count_next(line_next), .wrap(line_wrap)
  );

  ydriver_wrap_counter #(.N(FR_LINES), .W(FR_W)) u_fr (
    .clk(clk), .clr(clr), .en(dot_wrap), .count_next(fr_next), .wrap(fr_wrap)
  );

  // Outputs are decoded from the counters' next values so they line up with them.
  always_comb begin
    state_d = clr ? ST_IDLE : ST_RUN;
    going   = (state_d == ST_RUN);
    s_d     = going && (line_next == '0);
    ls_d    = going && (dot_next == '0);
    fs_d    = ls_d && (line_next == '0);
    cpl_d   = going && (32'(dot_next) >= CPL_START) &&
              (32'(dot_next) < CPL_START + CPL_WIDTH);
    fr_d    = going && (FR ^ fr_wrap);
    ly_d    = going ? line_next : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      S            <= 1'b0;
      CPL          <= 1'b0;
      FR           <= 1'b0;
      line_strobe  <= 1'b0;
      frame_strobe <= 1'b0;
      ly           <= '0;
      active       <= 1'b0;
    end else begin
      state_q      <= state_d;
      S            <= s_d;
      CPL          <= cpl_d;
      FR           <= fr_d;
      line_strobe  <= ls_d;
      frame_strobe <= fs_d;
      ly           <= ly_d;
      active       <= going;
    end
  end

  a_fr_range:   assert property (@(posedge clk) 32'(fr_next) < FR_LINES);
  a_line_chain: assert property (@(posedge clk) line_wrap |-> dot_wrap);

endmodule

// File: tb/tb_ydriver_timing_gen.sv
// Directed plus random bench for ydriver_timing_gen, default and small parameter sets.
module tb_ydriver_timing_gen;

  typedef struct packed {
    logic       s;
    logic       cpl;
    logic       fr;
    logic       ls;
    logic       fs;
    logic       act;
    logic [7:0] ly;
  } exp_t;

  localparam int FRAME_A = 456 * 154;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lcd_on = 1'b0;

  logic s_a, cpl_a, fr_a, ls_a, fs_a, act_a;
  logic s_b, cpl_b, fr_b, ls_b, fs_b, act_b;
  logic [7:0] ly_a, ly_b;

  int total = 0;
  int bad = 0;
  int t = -1;

  bit mon = 1'b0;
  int cpl_rises = 0, s_rises = 0, both_rises = 0;
  logic p_cpl = 1'b0, p_s = 1'b0, p_fr_a = 1'b0, p_fr_b = 1'b0;
  int fs_big[$], fr_big[$], fs_small[$], fr_small[$];

  always #5 clk = ~clk;

  ydriver_timing_gen u_big (
    .clk(clk), .rst(rst), .lcd_on(lcd_on),
    .S(s_a), .CPL(cpl_a), .FR(fr_a), .line_strobe(ls_a), .frame_strobe(fs_a),
    .ly(ly_a), .active(act_a)
  );

  ydriver_timing_gen #(
    .CLKS_PER_LINE(16), .LINES_PER_FRAME(4), .CPL_START(2), .CPL_WIDTH(3), .FR_LINES(3)
  ) u_small (
    .clk(clk), .rst(rst), .lcd_on(lcd_on),
    .S(s_b), .CPL(cpl_b), .FR(fr_b), .line_strobe(ls_b), .frame_strobe(fs_b),
    .ly(ly_b), .active(act_b)
  );

  // t = clocks since the first active cycle (-1 when idle); outputs follow by arithmetic.
  function automatic exp_t model(input int tt, input int cpl_n, input int lpf,
                                 input int cs, input int cw, input int frl);
    exp_t e;
    int dot, b, line;
    e = '0;
    if (tt >= 0) begin
      dot   = tt % cpl_n;
      b     = tt / cpl_n;
      line  = b % lpf;
      e.act = 1'b1;
      e.s   = (line == 0);
      e.cpl = (dot >= cs) && (dot < cs + cw);
      e.fr  = ((b / frl) % 2) == 1;
      e.ls  = (dot == 0);
      e.fs  = (dot == 0) && (line == 0);
      e.ly  = 8'(line);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input string tag);
    exp_t obs, e;
    @(posedge clk);
    if (rst || !lcd_on) t = -1;
    else if (t < 0)     t = 0;
    else                t++;
    #1;
    obs = '{s_a, cpl_a, fr_a, ls_a, fs_a, act_a, ly_a};
    e = model(t, 456, 154, 8, 4, 13);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s/big t=%0d got=%b expected=%b (s cpl fr ls fs act ly)", tag, t, obs, e);
    end
    obs = '{s_b, cpl_b, fr_b, ls_b, fs_b, act_b, ly_b};
    e = model(t, 16, 4, 2, 3, 3);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s/small t=%0d got=%b expected=%b (s cpl fr ls fs act ly)", tag, t, obs, e);
    end
    if (mon) begin
      if (t >= 0 && t < FRAME_A) begin
        if (cpl_a && !p_cpl) cpl_rises++;
        if (s_a && !p_s) s_rises++;
        if (cpl_a && !p_cpl && s_a && !p_s) both_rises++;
      end
      if (fs_a) fs_big.push_back(t);
      if (fr_a !== p_fr_a) fr_big.push_back(t);
      if (fs_b) fs_small.push_back(t);
      if (fr_b !== p_fr_b) fr_small.push_back(t);
    end
    p_cpl  = cpl_a;
    p_s    = s_a;
    p_fr_a = fr_a;
    p_fr_b = fr_b;
  endtask

  initial begin
    int n_fr;
    // Reset state
    rst = 1'b1; lcd_on = 1'b0;
    for (int i = 0; i < 3; i++) step("reset");
    lcd_on = 1'b1;
    step("reset_lcd_on");

    // Power-up start, one full frame and into the next
    rst = 1'b0;
    mon = 1'b1;
    for (int i = 0; i < FRAME_A + 2 * 456 + 10; i++) step("run");
    mon = 1'b0;
    chk("first_active_fs", (fs_big.size() > 0) ? fs_big[0] : -1, 0);
    chk("cpl_pulses_frame", cpl_rises, 154);
    chk("s_pulses_frame", s_rises, 1);
    chk("s_cpl_same_rise", both_rises, 0);
    chk("fs_count_big", fs_big.size(), 2);
    if (fs_big.size() >= 2) chk("frame_period_big", fs_big[1] - fs_big[0], FRAME_A);
    chk("fr_toggle_count_big", fr_big.size(), 12);
    if (fr_big.size() >= 2) begin
      chk("fr_toggle1_big", fr_big[0], 5928);
      chk("fr_toggle2_big", fr_big[1], 11856);
    end
    n_fr = 0;
    foreach (fr_big[i]) if (fr_big[i] < FRAME_A) n_fr++;
    chk("fr_toggles_in_frame", n_fr, 11);
    if (fs_small.size() >= 2) chk("frame_period_small", fs_small[1] - fs_small[0], 64);
    else chk("fs_count_small", fs_small.size(), 2);
    if (fr_small.size() >= 3) begin
      chk("fr_toggle1_small", fr_small[0], 48);
      chk("fr_toggle2_small", fr_small[1], 96);
      chk("fr_toggle3_small", fr_small[2], 144);
    end else chk("fr_toggle_count_small", fr_small.size(), 3);

    // Now at line 2 dot 9 of frame 2 (CPL high): drop lcd_on mid-pulse
    chk("pre_drop_cpl", int'(cpl_a), 1);
    lcd_on = 1'b0;
    step("drop");
    chk("drop_cpl", int'(cpl_a), 0);
    chk("drop_active", int'(act_a), 0);
    lcd_on = 1'b1;
    step("reenable");
    chk("reenable_fs", int'(fs_a), 1);
    for (int i = 0; i < 600; i++) step("after_reenable");

    // rst together with lcd_on mid-frame
    rst = 1'b1;
    step("rst_mid");
    chk("rst_mid_ly", int'(ly_a), 0);
    rst = 1'b0;
    for (int i = 0; i < 500; i++) step("after_rst");

    // One-clock lcd_on pulse
    lcd_on = 1'b0;
    step("pulse_idle");
    lcd_on = 1'b1;
    step("pulse_on");
    chk("pulse_s", int'(s_a), 1);
    lcd_on = 1'b0;
    step("pulse_off");
    chk("pulse_off_active", int'(act_a), 0);

    // Random enable/reset traffic
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      lcd_on = ($urandom_range(0, 29) != 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
